// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction/operand request and downstream ALU issue response.
// ALU_ISSUE_PERF_CNT_EN adds the issue/stall counter outputs.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_sel;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, op1, op2, alu_sel, rd, wb_en, illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    , input issue_cnt, stall_cnt
`endif
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, op1, op2, alu_sel, rd, wb_en, illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    , output issue_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes R/OP-IMM/LUI/AUIPC into op1/op2/alu_sel behind a 2-entry skid buffer.
// Optional ALU_ISSUE_PERF_CNT_EN adds issue_cnt/stall_cnt counters.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] SEL_ADD = 4'd0, SEL_SUB = 4'd1, SEL_PASS = 4'd2, SEL_SLL = 4'd3,
                         SEL_SRL = 4'd4, SEL_SRA = 4'd5, SEL_XOR  = 4'd6, SEL_OR  = 4'd7,
                         SEL_AND = 4'd8, SEL_SLT = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      sel;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } iss_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign f7  = bus.instr[31:25];

  iss_t            dec;
  logic            lgl;
  logic [3:0]      sel;
  logic [XLEN-1:0] a, b;

  always_comb begin
    lgl = 1'b0;
    sel = SEL_ADD;
    a   = bus.rs1_data;
    b   = bus.rs2_data;
    case (opc)
      OPC_R: begin
        case (f3)
          3'b000: begin lgl = (f7 == 7'h00) || (f7 == 7'h20); sel = f7[5] ? SEL_SUB : SEL_ADD; end
          3'b001: begin lgl = (f7 == 7'h00); sel = SEL_SLL; b = {27'b0, bus.rs2_data[4:0]}; end
          3'b010: begin lgl = (f7 == 7'h00); sel = SEL_SLT; end
          3'b100: begin lgl = (f7 == 7'h00); sel = SEL_XOR; end
          3'b101: begin
            lgl = (f7 == 7'h00) || (f7 == 7'h20);
            sel = f7[5] ? SEL_SRA : SEL_SRL;
            b   = {27'b0, bus.rs2_data[4:0]};
          end
          3'b110: begin lgl = (f7 == 7'h00); sel = SEL_OR;  end
          3'b111: begin lgl = (f7 == 7'h00); sel = SEL_AND; end
          default: lgl = 1'b0; // sltu
        endcase
      end
      OPC_IMM: begin
        b = {{20{bus.instr[31]}}, bus.instr[31:20]};
        case (f3)
          3'b000: begin lgl = 1'b1; sel = SEL_ADD; end
          3'b010: begin lgl = 1'b1; sel = SEL_SLT; end
          3'b100: begin lgl = 1'b1; sel = SEL_XOR; end
          3'b110: begin lgl = 1'b1; sel = SEL_OR;  end
          3'b111: begin lgl = 1'b1; sel = SEL_AND; end
          3'b001: begin lgl = (f7 == 7'h00); sel = SEL_SLL; b = {27'b0, bus.instr[24:20]}; end
          3'b101: begin
            lgl = (f7 == 7'h00) || (f7 == 7'h20);
            sel = f7[5] ? SEL_SRA : SEL_SRL;
            b   = {27'b0, bus.instr[24:20]};
          end
          default: lgl = 1'b0; // sltiu
        endcase
      end
      OPC_LUI: begin
        lgl = 1'b1; sel = SEL_PASS; a = '0; b = {bus.instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        lgl = 1'b1; sel = SEL_ADD; a = bus.pc; b = {bus.instr[31:12], 12'b0};
      end
      default: lgl = 1'b0;
    endcase

    dec.op1     = lgl ? a : '0;
    dec.op2     = lgl ? b : '0;
    dec.sel     = lgl ? sel : SEL_ADD;
    dec.rd      = bus.instr[11:7];
    dec.wb_en   = lgl && (bus.instr[11:7] != 5'd0);
    dec.illegal = !lgl;
  end

  iss_t main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, in_rdy_q;
  logic in_fire, out_fire;

  assign in_fire  = bus.in_valid && in_rdy_q;
  assign out_fire = main_vld_q && bus.out_ready;

  // in_ready is low only while skid is full, so skid full never coincides with in_fire.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (out_fire) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!main_vld_q || out_fire) begin
      main_vld_d = in_fire;
      if (in_fire) main_d = dec;
    end else if (in_fire) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= !skid_vld_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = main_vld_q;
  assign bus.op1       = main_q.op1;
  assign bus.op2       = main_q.op2;
  assign bus.alu_sel   = main_q.sel;
  assign bus.rd        = main_q.rd;
  assign bus.wb_en     = main_q.wb_en;
  assign bus.illegal   = main_q.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_fire)                       issue_cnt_q <= issue_cnt_q + 32'd1;
      if (main_vld_q && !bus.out_ready)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.issue_cnt = issue_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized + directed bench for alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n;
  alu_issue_if bus();

  alu_issue_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1, op2;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wb, ill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_err = 0;
  int   m_issue = 0, m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: look up the mnemonic's ALU op and operand forms, then apply the illegal/wb rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int sel = -1;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic [31:0] a = r1, b = r2;
    logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] up  = {ins[31:12], 12'h000};
    bit shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (opc == 7'h33) begin
      if (f7 == 7'h00)
        case (f3) 0: sel = 0; 1: sel = 3; 2: sel = 9; 4: sel = 6; 5: sel = 4; 6: sel = 7; 7: sel = 8; default: ; endcase
      else if (f7 == 7'h20 && f3 == 0) sel = 1;
      else if (f7 == 7'h20 && f3 == 5) sel = 5;
      if (shift) b = r2 % 32;
    end else if (opc == 7'h13) begin
      b = imm;
      case (f3)
        0: sel = 0; 2: sel = 9; 4: sel = 6; 6: sel = 7; 7: sel = 8;
        1: if (f7 == 0) sel = 3;
        5: sel = (f7 == 0) ? 4 : (f7 == 7'h20) ? 5 : -1;
        default: ;
      endcase
      if (shift) b = 32'(ins[24:20]);
    end else if (opc == 7'h37) begin
      sel = 2; a = 0; b = up;
    end else if (opc == 7'h17) begin
      sel = 0; a = pc; b = up;
    end
    e.rd  = ins[11:7];
    e.ill = (sel < 0);
    e.op1 = e.ill ? 32'd0 : a;
    e.op2 = e.ill ? 32'd0 : b;
    e.sel = e.ill ? 4'd0 : 4'(sel);
    e.wb  = !e.ill && (e.rd != 0);
    return e;
  endfunction

  task automatic sb_check();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
    if (bus.out_valid && q.size() > 0) begin
      chk("op1",     bus.op1,              q[0].op1);
      chk("op2",     bus.op2,              q[0].op2);
      chk("alu_sel", 32'(bus.alu_sel),     32'(q[0].sel));
      chk("rd",      32'(bus.rd),          32'(q[0].rd));
      chk("wb_en",   32'(bus.wb_en),       32'(q[0].wb));
      chk("illegal", 32'(bus.illegal),     32'(q[0].ill));
    end
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("issue_cnt", bus.issue_cnt, 32'(m_issue));
    chk("stall_cnt", bus.stall_cnt, 32'(m_stall));
`endif
  endtask

  // Called at a negedge: drive, clock once, update the model, check at the next negedge.
  task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
    bit ifire, ofire, stall;
    bus.in_valid = v; bus.instr = ins; bus.pc = pc;
    bus.rs1_data = r1; bus.rs2_data = r2; bus.out_ready = ordy;
    ifire = v && (q.size() < 2);
    ofire = (q.size() > 0) && ordy;
    stall = (q.size() > 0) && !ordy;
    @(posedge clk);
    if (ofire) begin void'(q.pop_front()); m_issue++; end
    if (stall) m_stall++;
    if (ifire) q.push_back(model(ins, pc, r1, r2));
    @(negedge clk);
    sb_check();
  endtask

  task automatic check_reset_state();
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst in_ready",  32'(bus.in_ready),  1);
    chk("rst op1",       bus.op1, 0);
    chk("rst op2",       bus.op2, 0);
    chk("rst alu_sel",   32'(bus.alu_sel), 0);
    chk("rst rd",        32'(bus.rd), 0);
    chk("rst wb_en",     32'(bus.wb_en), 0);
    chk("rst illegal",   32'(bus.illegal), 0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("rst issue_cnt", bus.issue_cnt, 0);
    chk("rst stall_cnt", bus.stall_cnt, 0);
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom();
    logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h00};
    logic [6:0]  f7;
    int k = $urandom_range(0, 5);
    f7s[2] = 7'($urandom());
    f7 = f7s[$urandom_range(0, 2)];
    case (k)
      0: begin
        w[6:0] = 7'h33;
        w[31:25] = (w[14:12] inside {3'd4, 3'd6, 3'd7}) ? 7'h00 : f7;
      end
      1, 2: begin
        w[6:0] = 7'h13;
        if (w[14:12] inside {3'd1, 3'd5}) w[31:25] = f7;
      end
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instr = 0; bus.pc = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // ADDI x1, x0, 5
    tick(1, 32'h00500093, 32'h100, 32'd0, 32'd0, 1);
    chk("addi op2", bus.op2, 5);
    chk("addi rd",  32'(bus.rd), 1);
    chk("addi wb",  32'(bus.wb_en), 1);
    // SUB x3, x1, x2
    tick(1, 32'h402081B3, 32'h104, 32'd10, 32'd3, 1);
    chk("sub op1", bus.op1, 10);
    chk("sub sel", 32'(bus.alu_sel), 1);
    // SRAI x5 then LUI x7
    tick(1, 32'h40335293, 32'h108, 32'h80000000, 32'd0, 1);
    chk("srai op2", bus.op2, 3);
    chk("srai sel", 32'(bus.alu_sel), 5);
    tick(1, 32'h123453B7, 32'h10C, 32'd0, 32'd0, 1);
    chk("lui op2", bus.op2, 32'h12345000);
    chk("lui sel", 32'(bus.alu_sel), 2);

    // Backpressure: A then B with out_ready low, then drain.
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 32'h00700113, 32'h200, 32'd1, 32'd0, 0);
    tick(1, 32'h00208233, 32'h204, 32'd4, 32'd5, 0);
    chk("bp in_ready low", 32'(bus.in_ready), 0);
    chk("bp A held rd", 32'(bus.rd), 2);
    tick(1, 32'h00100013, 32'h208, 32'd0, 32'd0, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("bp B rd", 32'(bus.rd), 4);
    tick(0, 0, 0, 0, 0, 1);
    chk("bp drained", 32'(bus.out_valid), 0);

    // Illegal and x0 destination cases.
    tick(1, 32'h0000000B, 32'h300, 32'd7, 32'd8, 1);
    chk("custom0 illegal", 32'(bus.illegal), 1);
    chk("custom0 op1", bus.op1, 0);
    tick(1, 32'h0020B1B3, 32'h304, 32'd7, 32'd8, 1);
    chk("sltu illegal", 32'(bus.illegal), 1);
    chk("sltu wb", 32'(bus.wb_en), 0);
    tick(1, 32'h00500013, 32'h308, 32'd0, 32'd0, 1);
    chk("addi x0 illegal", 32'(bus.illegal), 0);
    chk("addi x0 wb", 32'(bus.wb_en), 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 9) < 7), rand_instr(), $urandom(), $urandom(), $urandom(),
           ($urandom_range(0, 9) < 6));

    // Reset with both entries full.
    tick(1, 32'h00500093, 32'h400, 0, 0, 0);
    tick(1, 32'h00500093, 32'h404, 0, 0, 0);
    tick(1, 32'h00500093, 32'h408, 0, 0, 0);
    chk("full before reset", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    bus.in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_issue = 0;
    m_stall = 0;
    check_reset_state();
    tick(1, 32'h00500093, 32'h500, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Issue/decode stage that drives the ALU operand interface: op1, op2 and the 4-bit alu_sel.
- Decodes RV32I R-type, OP-IMM, LUI and AUIPC instructions together with their register-file read data.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so in_ready is a pure register output.
- Sits between the register-read stage and the combinational ALU; the writeback stage consumes rd and wb_en.

Parameters:
XLEN, 32, datapath width of op1/op2/pc/rs data (only 32 is supported).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered
instr  in  32  RV32 instruction word
pc  in  32  instruction address
rs1_data  in  32  register-file read of instr[19:15]
rs2_data  in  32  register-file read of instr[24:20]
out_valid  out  1  issued operation valid
out_ready  in  1  downstream accepts
op1  out  32  ALU operand 1
op2  out  32  ALU operand 2
alu_sel  out  4  0 add, 1 sub, 2 pass-op2, 3 sll, 4 srl, 5 sra, 6 xor, 7 or, 8 and, 9 slt
rd  out  5  destination register
wb_en  out  1  write rd (0 when rd==0 or illegal)
illegal  out  1  instruction not supported by this stage

Behaviour:
Reset (rst_n==0 at a clk edge):
- Both buffer entries are emptied.
- out_valid=0, in_ready=1, op1=op2=0, alu_sel=0, rd=0, wb_en=0, illegal=0.
- Any in-flight operation is discarded.

Handshake:
- Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
- Latency is exactly 1 cycle from input transfer to out_valid when the buffer is empty.
- Main register drives the outputs. The skid register captures an accepted input when main is full and not draining that cycle.
- in_ready is registered and equals !skid_full.
- On output transfer with skid full, skid moves to main and skid empties.
- Simultaneous input and output transfer with skid empty: main loads the new entry; out_valid stays 1.
- Order is strictly preserved. Outputs are stable while out_valid&&!out_ready.

Decode, per opcode instr[6:0]:
- 0110011 (R-type), op1=rs1_data, op2={27'b0, rs2_data[4:0]} for shifts, rs2_data otherwise. alu_sel by funct3/funct7:
  - 000/0000000 add; 000/0100000 sub
  - 001/0000000 sll
  - 010/0000000 slt
  - 100 xor
  - 101/0000000 srl; 101/0100000 sra
  - 110 or; 111 and
- 0010011 (OP-IMM), op1=rs1_data, op2=sign-extended instr[31:20]:
  - addi, slti, xori, ori and andi map to alu_sel 0, 9, 6, 7, 8.
  - slli/srli/srai use op2={27'b0, instr[24:20]} and map to alu_sel 3/4/5; funct7 must be 0000000, or 0100000 for srai.
- 0110111 (LUI): op1=0, op2={instr[31:12], 12'b0}, alu_sel=2.
- 0010111 (AUIPC): op1=pc, op2={instr[31:12], 12'b0}, alu_sel=0.

Illegal cases:
- Covered: any other opcode, SLTU/SLTIU, and bad funct7.
- Response: illegal=1, wb_en=0, alu_sel=0, op1=op2=0, rd=instr[11:7].
- Illegal entries still flow through the handshake.

Writeback: wb_en=1 iff legal and rd!=0.

Optional Feature:
ALU_ISSUE_PERF_CNT_EN:
- When defined, adds two outputs, issue_cnt[31:0] and stall_cnt[31:0].
- Both are 0 on reset and wrap modulo 2^32.
- issue_cnt increments on each output transfer.
- stall_cnt increments each cycle with out_valid&&!out_ready.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. ADDI, instr=0x00500093, rs1_data=0 -> next cycle out_valid=1, op1=0, op2=5, alu_sel=0, rd=1, wb_en=1.
2. SUB, instr=0x402081B3, rs1_data=10, rs2_data=3 -> op1=10, op2=3, alu_sel=1, rd=3, wb_en=1.
3. SRAI, instr=0x40335293, rs1_data=0x80000000 -> op2=3, alu_sel=5, rd=5. LUI, instr=0x123453B7 -> op1=0, op2=0x12345000, alu_sel=2, rd=7.
4. Backpressure: out_ready=0, issue A then B -> in_ready=0 the cycle after B is accepted, and A is held stable. Then raise out_ready -> A, then B, emerge on consecutive cycles and in_ready returns to 1.
5. instr=0x0000000B (custom-0) and SLTU 0x0020B1B3 -> illegal=1, wb_en=0. ADDI x0 (0x00500013) -> illegal=0, wb_en=0.
6. Reset mid-operation: with both buffer entries full, assert rst_n=0 for one edge -> out_valid=0, in_ready=1, all outputs 0. Perf counters read 0 when ALU_ISSUE_PERF_CNT_EN is defined.
